dial_encoder: RTL and testbench

//  Front end for the safe's combination dial. Takes the raw quadrature pins of the rotary dial, then

---
 rtl/dial_encoder.sv | 132 +++++++++++++
 tb/tb_dial_encoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dial_encoder.sv
// Rotary combination-dial front end: synchronises and debounces the quadrature pins, decodes one step
// per detent, and tracks the wrapped dial position plus the step/direction/match flags for the sequencer.
module dial_encoder #(
    parameter int WIDTH      = 6,
    parameter int DIAL_MAX   = 40,
    parameter int DEB_CYCLES = 16,
    parameter int C0         = 10,
    parameter int C1         = 25,
    parameter int C2         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             countEn,
    input  logic             clrCount,
    input  logic [1:0]       sel,
    output logic             cnten,
    output logic             up,
    output logic             dirch,
    output logic             eq,
    output logic [WIDTH-1:0] count
);

    localparam int               CNT_W    = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [WIDTH-1:0] POS_MAX  = WIDTH'(DIAL_MAX - 1);

    // Bit 1 carries channel A and bit 0 channel B, so deb_q is directly the decode state {A,B}.
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            deb_q, deb_d;
    logic [1:0]            prev_q;
    logic [1:0][CNT_W-1:0] dcnt_q, dcnt_d;

    logic [WIDTH-1:0] count_q, count_d;
    logic             up_q, up_d;
    logic             cnten_q, cnten_d;
    logic             dirch_q, dirch_d;
    logic             eq_q, eq_d;
    logic             hist_q, hist_d;

    logic step_cw, step_ccw;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        deb_d  = deb_q;
        dcnt_d = dcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DEB_LAST) begin
                deb_d[i]  = sync2_q[i];
                dcnt_d[i] = '0;
            end else begin
                dcnt_d[i] = dcnt_q[i] + CNT_W'(1);
            end
        end
    end

    // One step per detent, taken only on the final return to the 00 rest state.
    assign step_cw  = (prev_q == 2'b10) && (deb_q == 2'b00);
    assign step_ccw = (prev_q == 2'b01) && (deb_q == 2'b00);

    always_comb begin
        count_d = count_q;
        up_d    = up_q;
        hist_d  = hist_q;
        cnten_d = 1'b0;
        dirch_d = 1'b0;
        if (clrCount) begin
            count_d = '0;
            hist_d  = 1'b0;
        end else if (countEn && (step_cw || step_ccw)) begin
            cnten_d = 1'b1;
            dirch_d = hist_q && (step_cw != up_q);
            hist_d  = 1'b1;
            up_d    = step_cw;
            if (step_cw) begin
                count_d = (count_q == POS_MAX) ? '0 : count_q + WIDTH'(1);
            end else begin
                count_d = (count_q == '0) ? POS_MAX : count_q - WIDTH'(1);
            end
        end
    end

    // Compared against the pre-update count, so eq trails count by one cycle.
    always_comb begin
        eq_d = 1'b0;
        case (sel)
            2'd0:    eq_d = (count_q == WIDTH'(C0));
            2'd1:    eq_d = (count_q == WIDTH'(C1));
            2'd2:    eq_d = (count_q == WIDTH'(C2));
            default: eq_d = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            deb_q   <= 2'b00;
            prev_q  <= 2'b00;
            dcnt_q  <= '0;
            count_q <= '0;
            up_q    <= 1'b1;
            cnten_q <= 1'b0;
            dirch_q <= 1'b0;
            eq_q    <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= {enc_a, enc_b};
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            prev_q  <= deb_q;
            dcnt_q  <= dcnt_d;
            count_q <= count_d;
            up_q    <= up_d;
            cnten_q <= cnten_d;
            dirch_q <= dirch_d;
            eq_q    <= eq_d;
            hist_q  <= hist_d;
        end
    end

    assign count = count_q;
    assign up    = up_q;
    assign cnten = cnten_q;
    assign dirch = dirch_q;
    assign eq    = eq_q;

endmodule

// File: tb/tb_dial_encoder.sv
// Bench for dial_encoder: directed scenarios followed by random detents, all checked against a
// position/direction model that works at the level of whole detents.
module tb_dial_encoder;

    localparam int DEB      = 4;
    localparam int DIAL_MAX = 40;

    logic       clk = 1'b0;
    logic       rst_n, enc_a, enc_b, countEn, clrCount;
    logic [1:0] sel;
    logic       cnten, up, dirch, eq;
    logic [5:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_count = 0;
    bit m_up    = 1'b1;
    bit m_hist  = 1'b0;

    dial_encoder #(
        .WIDTH(6), .DIAL_MAX(DIAL_MAX), .DEB_CYCLES(DEB), .C0(10), .C1(25), .C2(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
        .countEn(countEn), .clrCount(clrCount), .sel(sel),
        .cnten(cnten), .up(up), .dirch(dirch), .eq(eq), .count(count)
    );

    always #5 clk = ~clk;

    function automatic int digit(input logic [1:0] s);
        case (s)
            2'd0:    return 10;
            2'd1:    return 25;
            2'd2:    return 5;
            default: return -1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_quiet(input int n, input string tag);
        int pulses = 0;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            if (cnten !== 1'b0) pulses++;
            enc_a = 1'b0;
            enc_b = 1'b0;
        end
        check(tag, pulses, 0);
    endtask

    task automatic clear_count();
        @(negedge clk);
        clrCount = 1'b1;
        @(negedge clk);
        clrCount = 1'b0;
        m_count = 0;
        m_hist  = 1'b0;
        check("clear count", count, 0);
    endtask

    // One full detent, 8 cycles per quadrature phase, then a short settle window.
    task automatic detent(input bit cw, input bit en, input bit clr);
        logic [1:0]  ph [4];
        int          pulses, dpulses, orphan, first_t, old_count, d;
        bit          exp_pulse, exp_dirch, seen_prev;
        logic [31:0] cnt_at, eq_at, eq_after;

        old_count = m_count;
        d         = digit(sel);
        if (clr) begin
            exp_pulse = 1'b0;
            exp_dirch = 1'b0;
            m_count   = 0;
            m_hist    = 1'b0;
        end else if (!en) begin
            exp_pulse = 1'b0;
            exp_dirch = 1'b0;
        end else begin
            exp_pulse = 1'b1;
            exp_dirch = m_hist && (cw != m_up);
            m_count   = cw ? (m_count + 1) % DIAL_MAX : (m_count + DIAL_MAX - 1) % DIAL_MAX;
            m_up      = cw;
            m_hist    = 1'b1;
        end

        if (cw) ph = '{2'b01, 2'b11, 2'b10, 2'b00};
        else    ph = '{2'b10, 2'b11, 2'b01, 2'b00};

        countEn   = en;
        pulses    = 0;
        dpulses   = 0;
        orphan    = 0;
        first_t   = -1;
        seen_prev = 1'b0;
        cnt_at    = 'x;
        eq_at     = 'x;
        eq_after  = 'x;
        for (int t = 0; t < 36; t++) begin
            @(negedge clk);
            if (seen_prev) begin
                eq_after  = eq;
                seen_prev = 1'b0;
            end
            if (cnten === 1'b1) begin
                pulses++;
                if (first_t < 0) first_t = t;
                cnt_at    = count;
                eq_at     = eq;
                seen_prev = 1'b1;
            end
            if (dirch === 1'b1) begin
                dpulses++;
                if (cnten !== 1'b1) orphan++;
            end
            if (t < 32) begin
                {enc_a, enc_b} = ph[t / 8];
                clrCount       = clr && (t >= 28);
            end else begin
                {enc_a, enc_b} = 2'b00;
                clrCount       = 1'b0;
            end
        end

        check("cnten pulses", pulses, exp_pulse);
        check("dirch pulses", dpulses, exp_dirch);
        check("dirch without cnten", orphan, 0);
        if (exp_pulse) begin
            check("pin-to-cnten latency", first_t, 31);
            check("count at cnten", cnt_at, m_count);
            check("eq at cnten", eq_at, old_count == d);
            check("eq after cnten", eq_after, m_count == d);
        end
        check("count", count, m_count);
        check("up", up, m_up);
        check("eq settled", eq, m_count == d);
    endtask

    // Pulse enc_a high for len cycles from the 00 rest state; a pulse of DEB cycles or more is
    // a genuine 00->10->00 excursion and therefore decodes as one CW step.
    task automatic glitch_a(input int len);
        int pulses = 0;
        bit accept = (len >= DEB);
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            if (cnten === 1'b1) pulses++;
            enc_a = (t < len);
            enc_b = 1'b0;
        end
        if (accept && countEn) begin
            m_count = (m_count + 1) % DIAL_MAX;
            m_up    = 1'b1;
            m_hist  = 1'b1;
        end
        check($sformatf("glitch len %0d pulses", len), pulses, accept && countEn);
        check($sformatf("glitch len %0d count", len), count, m_count);
    endtask

    initial begin
        rst_n    = 1'b0;
        enc_a    = 1'b0;
        enc_b    = 1'b0;
        countEn  = 1'b0;
        clrCount = 1'b0;
        sel      = 2'd3;

        // Reset state and quiet pins after release.
        #12;
        check("reset count", count, 0);
        check("reset up", up, 1);
        check("reset cnten", cnten, 0);
        check("reset dirch", dirch, 0);
        check("reset eq", eq, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_quiet(12, "idle after reset");

        // Clean CW detents.
        for (int i = 0; i < 3; i++) detent(1'b1, 1'b1, 1'b0);

        // Wrap below zero, then turn back across zero.
        clear_count();
        detent(1'b0, 1'b1, 1'b0);
        detent(1'b1, 1'b1, 1'b0);

        // Bounce rejection, then the shortest accepted pulse.
        for (int i = 0; i < 5; i++) glitch_a(3);
        for (int i = 0; i < 3; i++) glitch_a(int'($urandom_range(1, DEB - 1)));
        glitch_a(DEB);

        // Digit match at the turnaround position.
        sel = 2'd0;
        clear_count();
        for (int i = 0; i < 10; i++) detent(1'b1, 1'b1, 1'b0);
        detent(1'b0, 1'b1, 1'b0);

        // Gating and clear-versus-step priority.
        detent(1'b1, 1'b0, 1'b0);
        detent(1'b1, 1'b0, 1'b0);
        detent(1'b1, 1'b1, 1'b1);
        detent(1'b1, 1'b1, 1'b0);

        // Random detents.
        for (int i = 0; i < 40; i++) begin
            sel = 2'($urandom_range(0, 3));
            detent(1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0);
        end

        // Asynchronous reset asserted mid-cycle from a non-reset state.
        detent(1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        m_count = 0;
        m_up    = 1'b1;
        m_hist  = 1'b0;
        check("async reset count", count, m_count);
        check("async reset up", up, m_up);
        check("async reset cnten", cnten, 0);
        check("async reset dirch", dirch, 0);
        check("async reset eq", eq, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_quiet(8, "idle after async reset");
        detent(1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
